alu_writeback_stage: RTL

Pipeline stage directly downstream of the ALU: accepts each ALU result with its flags, opcode and destination register through a valid/ready handshake, buffers it, and presents it to the register-file write port. Commits the architectural flag register (C, S, O, Z) and counts retired instructions on retirement. Latches the halted state when an `OP_HLT` retires. Sits between the ALU and the register file in the CPU datapath.

---
 rtl/alu_writeback_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// Writeback stage between the ALU and the register file: buffers ALU results,
// commits flags, counts retirements and latches halt. Define ALU_WB_SKID_EN for a 2-entry skid buffer.

`ifndef OP_NOP
`define OP_NOP 5'h00
`endif
`ifndef OP_ADD
`define OP_ADD 5'h01
`endif
`ifndef OP_SUB
`define OP_SUB 5'h02
`endif
`ifndef OP_AND
`define OP_AND 5'h03
`endif
`ifndef OP_OR
`define OP_OR 5'h04
`endif
`ifndef OP_XOR
`define OP_XOR 5'h05
`endif
`ifndef OP_HLT
`define OP_HLT 5'h1F
`endif

module alu_writeback_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int OPCODE_W = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   resultado,
    input  logic                alu_c,
    input  logic                alu_s,
    input  logic                alu_o,
    input  logic                alu_z,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [REG_W-1:0]    rd,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic                wb_we,
    output logic [REG_W-1:0]    wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic [3:0]          flags,
    output logic                halted,
    output logic [31:0]         retired
);

    // Handshakes: a transfer happens at a rising edge where valid && ready are both 1;
    // a producer holding valid keeps its payload stable until that edge.

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [REG_W-1:0]    rd;
        logic [OPCODE_W-1:0] op;
        logic [3:0]          fl;
    } entry_t;

    function automatic logic is_hlt(input logic [OPCODE_W-1:0] op);
        return op == OPCODE_W'(`OP_HLT);
    endfunction

    function automatic logic writes_back(input logic [OPCODE_W-1:0] op);
        return !(op == OPCODE_W'(`OP_NOP) || is_hlt(op));
    endfunction

    entry_t     in_entry;
    entry_t     head;
    logic       accept;
    logic       retire;
    logic       hlt_pending;
    logic       halted_q;
    logic       hlt_pending_nxt;
    logic       halted_nxt;
    logic [3:0] flags_q;
    logic [31:0] retired_q;

    assign in_entry = {resultado, rd, opcode, alu_c, alu_s, alu_o, alu_z};
    assign accept   = in_valid && in_ready;

    assign wb_we   = writes_back(head.op);
    assign wb_rd   = head.rd;
    assign wb_data = head.data;
    assign flags   = flags_q;
    assign halted  = halted_q;
    assign retired = retired_q;

    // A retiring HLT is always the youngest entry, so it cannot coincide with accepting one.
    always_comb begin
        hlt_pending_nxt = hlt_pending;
        halted_nxt      = halted_q;
        if (accept && is_hlt(in_entry.op))
            hlt_pending_nxt = 1'b1;
        if (retire && is_hlt(head.op)) begin
            hlt_pending_nxt = 1'b0;
            halted_nxt      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hlt_pending <= 1'b0;
            halted_q    <= 1'b0;
            flags_q     <= 4'b0000;
            retired_q   <= 32'd0;
        end else begin
            hlt_pending <= hlt_pending_nxt;
            halted_q    <= halted_nxt;
            if (retire) begin
                if (writes_back(head.op))
                    flags_q <= head.fl;
                if (retired_q != 32'hFFFF_FFFF)
                    retired_q <= retired_q + 32'd1;
            end
        end
    end

`ifdef ALU_WB_SKID_EN

    // slot0 is always the head; slot1 holds the younger entry when two are buffered.
    entry_t     slot0;
    entry_t     slot1;
    logic [1:0] count;
    logic [1:0] count_nxt;
    logic       in_ready_q;

    assign wb_valid  = (count != 2'd0);
    assign head      = slot0;
    assign retire    = wb_valid && wb_ready;
    assign count_nxt = count + 2'(accept) - 2'(retire);
    assign in_ready  = in_ready_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            count      <= count_nxt;
            in_ready_q <= (count_nxt != 2'd2) && !hlt_pending_nxt && !halted_nxt;
        end
    end

    always_ff @(posedge clk) begin
        case ({accept, retire})
            2'b10: begin
                if (count == 2'd0)
                    slot0 <= in_entry;
                else
                    slot1 <= in_entry;
            end
            2'b01: slot0 <= slot1;
            2'b11: begin
                if (count == 2'd1) begin
                    slot0 <= in_entry;
                end else begin
                    slot0 <= slot1;
                    slot1 <= in_entry;
                end
            end
            default: ;
        endcase
    end

`else

    entry_t slot;
    logic   full;

    assign wb_valid = full;
    assign head     = slot;
    assign retire   = full && wb_ready;
    // Accepting into a slot that is retiring this same edge keeps one bundle per cycle.
    assign in_ready = (!full || wb_ready) && !hlt_pending && !halted_q && !reset;

    always_ff @(posedge clk) begin
        if (reset)
            full <= 1'b0;
        else if (accept)
            full <= 1'b1;
        else if (retire)
            full <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept)
            slot <= in_entry;
    end

`endif

endmodule
